// File: rtl/tms9918_pkg.sv
// tms9918_pkg: shared FSM state encoding and line-length limit for the scandoubler controller
package tms9918_pkg;

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        LOCKED
    } ctrl_state_t;

    localparam logic [8:0] LINE_MAX = 9'd511;

endpackage

// File: rtl/tms9918_pixel_strobe.sv
// tms9918_pixel_strobe: phase counter producing input (every DIV clks) and output (every DIV/2 clks) pixel strobes
module tms9918_pixel_strobe #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic clk_en_in,
    output logic clk_en_out
);

    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] HALF = PW'(DIV / 2 - 1);

    logic [PW-1:0] phase;
    logic          armed;

    // Strobes are registered so they land on the clk where the phase wraps; the mid-pixel
    // output strobe is held off until the first full input pixel has elapsed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase      <= '0;
            armed      <= 1'b0;
            clk_en_in  <= 1'b0;
            clk_en_out <= 1'b0;
        end else begin
            phase      <= (phase == LAST) ? '0 : phase + 1'b1;
            armed      <= armed | (phase == LAST);
            clk_en_in  <= phase == LAST;
            clk_en_out <= (phase == LAST) || (armed && phase == HALF);
        end
    end

endmodule

// File: rtl/tms9918_scandoubler_ctrl.sv
// tms9918_scandoubler_ctrl: line-length measurement and lock FSM for the line doubler; TMS9918_SCANDOUBLER_CTRL_STATS_EN adds unlock_count
module tms9918_scandoubler_ctrl
    import tms9918_pkg::*;
#(
    parameter int DIV        = 4,
    parameter int LOCK_LINES = 4,
    parameter int MIN_WIDTH  = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sync_h_in,
    output logic       clk_en_in,
    output logic       clk_en_out,
    output logic [8:0] line_width,
    output logic       locked,
    output logic       bypass
`ifdef TMS9918_SCANDOUBLER_CTRL_STATS_EN
    ,
    output logic [7:0] unlock_count
`endif
);

    localparam logic [8:0] MIN_W    = 9'(MIN_WIDTH);
    localparam logic [3:0] LOCK_TOP = 4'(LOCK_LINES - 1);

    ctrl_state_t state;
    logic [8:0]  cnt;
    logic [3:0]  match_cnt;
    logic        sync_prev;
    logic        edge_ok;
    logic        same;
    logic        sat;

    tms9918_pixel_strobe #(.DIV(DIV)) u_strobe (
        .clk       (clk),
        .reset     (reset),
        .clk_en_in (clk_en_in),
        .clk_en_out(clk_en_out)
    );

    assign edge_ok = sync_h_in && !sync_prev && (cnt >= MIN_W);
    assign same    = cnt == line_width;
    assign sat     = cnt == LINE_MAX;

    // Sync edge tracking, pixel counting and lock FSM, all advanced once per input pixel;
    // a valid edge always takes priority over counter saturation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= SEARCH;
            cnt        <= '0;
            match_cnt  <= '0;
            line_width <= '0;
            sync_prev  <= 1'b0;
            locked     <= 1'b0;
            bypass     <= 1'b1;
`ifdef TMS9918_SCANDOUBLER_CTRL_STATS_EN
            unlock_count <= '0;
`endif
        end else begin
            locked <= state == LOCKED;
            bypass <= state != LOCKED;
            if (clk_en_in) begin
                sync_prev <= sync_h_in;
                cnt       <= edge_ok ? 9'd1 : (sat ? cnt : cnt + 9'd1);
                if (edge_ok) begin
                    case (state)
                        SEARCH: begin
                            state     <= MEASURE;
                            match_cnt <= '0;
                        end
                        MEASURE: begin
                            line_width <= cnt;
                            match_cnt  <= same ? match_cnt + 4'd1 : 4'd0;
                            if (same && match_cnt + 4'd1 == LOCK_TOP)
                                state <= LOCKED;
                        end
                        default: begin
                            if (!same) begin
                                state      <= MEASURE;
                                match_cnt  <= '0;
                                line_width <= cnt;
`ifdef TMS9918_SCANDOUBLER_CTRL_STATS_EN
                                unlock_count <= unlock_count + {7'd0, unlock_count != 8'hFF};
`endif
                            end
                        end
                    endcase
                end else if (sat && state != SEARCH) begin
                    state     <= SEARCH;
                    match_cnt <= '0;
`ifdef TMS9918_SCANDOUBLER_CTRL_STATS_EN
                    if (state == LOCKED)
                        unlock_count <= unlock_count + {7'd0, unlock_count != 8'hFF};
`endif
                end
            end
        end
    end

endmodule
